// File: rtl/cache_pkg.sv
// Shared geometry, state encoding and word-select helper for the direct-mapped
// write-back data cache.
package cache_pkg;
   localparam int TAG_W     = 25;
   localparam int IDX_W     = 3;
   localparam int OFS_W     = 2;
   localparam int LINE_W    = 128;
   localparam int NUM_LINES = 8;
   localparam int WORD_W    = 32;

   typedef enum logic [1:0] {
      COMPARE   = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFS_W-1:0]  ofs);
      return line[{ofs, 5'b0} +: WORD_W];
   endfunction
endpackage

// File: rtl/dcache_line_array.sv
// Tag/data storage for 8 lines x 4 words. Only valid/dirty are reset; tags and
// data are don't-care after reset.
module dcache_line_array
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  idx,
   output logic              rd_valid,
   output logic              rd_dirty,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [LINE_W-1:0] rd_line,
   input  logic              wr_word_en,
   input  logic [OFS_W-1:0]  wr_ofs,
   input  logic [WORD_W-1:0] wr_word,
   input  logic              wr_line_en,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_line
);
   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (wr_line_en) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (wr_word_en) begin
         dirty_q[idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_line_en) begin
         tag_q[idx]  <= wr_tag;
         data_q[idx] <= wr_line;
      end else if (wr_word_en) begin
         data_q[idx][{wr_ofs, 5'b0} +: WORD_W] <= wr_word;
      end
   end

   assign rd_valid = valid_q[idx];
   assign rd_dirty = dirty_q[idx];
   assign rd_tag   = tag_q[idx];
   assign rd_line  = data_q[idx];
endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: COMPARE / WRITEBACK /
// ALLOCATE controller around dcache_line_array.
module dcache
   import cache_pkg::*;
(
   input  logic         clk,
   input  logic         proc_reset,
   input  logic         proc_read,
   input  logic         proc_write,
   input  logic [29:0]  proc_addr,
   input  logic [31:0]  proc_wdata,
   output logic         proc_stall,
   output logic [31:0]  proc_rdata,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
);
   state_t            state_q, state_d;
   logic [TAG_W-1:0]  addr_tag;
   logic [IDX_W-1:0]  addr_idx;
   logic [OFS_W-1:0]  addr_ofs;
   logic              req, hit;
   logic              rd_valid, rd_dirty;
   logic [TAG_W-1:0]  rd_tag;
   logic [LINE_W-1:0] rd_line;
   logic              wr_word_en, wr_line_en;

   assign addr_tag = proc_addr[29:5];
   assign addr_idx = proc_addr[4:2];
   assign addr_ofs = proc_addr[1:0];
   assign req      = proc_read | proc_write;
   assign hit      = rd_valid && (rd_tag == addr_tag);

   dcache_line_array u_lines (
      .clk        (clk),
      .rst        (proc_reset),
      .idx        (addr_idx),
      .rd_valid   (rd_valid),
      .rd_dirty   (rd_dirty),
      .rd_tag     (rd_tag),
      .rd_line    (rd_line),
      .wr_word_en (wr_word_en),
      .wr_ofs     (addr_ofs),
      .wr_word    (proc_wdata),
      .wr_line_en (wr_line_en),
      .wr_tag     (addr_tag),
      .wr_line    (mem_rdata)
   );

   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) state_q <= COMPARE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         COMPARE:   if (req && !hit) state_d = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
         WRITEBACK: if (mem_ready) state_d = ALLOCATE;
         ALLOCATE:  if (mem_ready) state_d = COMPARE;
         default:   state_d = COMPARE;
      endcase
   end

   // Everything is forced to zero while reset is held, including the array write enables.
   always_comb begin
      proc_stall = 1'b0;
      proc_rdata = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      wr_word_en = 1'b0;
      wr_line_en = 1'b0;
      if (!proc_reset) begin
         case (state_q)
            COMPARE: begin
               proc_stall = req && !hit;
               proc_rdata = line_word(rd_line, addr_ofs);
               wr_word_en = proc_write && hit;
            end
            WRITEBACK: begin
               proc_stall = 1'b1;
               mem_write  = 1'b1;
               mem_addr   = {rd_tag, addr_idx};
               mem_wdata  = rd_line;
            end
            ALLOCATE: begin
               proc_stall = 1'b1;
               mem_read   = 1'b1;
               mem_addr   = proc_addr[29:2];
               wr_line_en = mem_ready;
            end
            default: ;
         endcase
      end
   end
endmodule
